// File: rtl/alarm_sequencer.sv
// Alarm sequencer: debounces the snooze/off buttons, times ring and snooze
// periods in one-second ticks and drives the tone generator start/stop.
module alarm_sequencer #(
    parameter int unsigned TICK_CYCLES      = 62500000,
    parameter int unsigned DEBOUNCE_CYCLES  = 625000,
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZES      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_en,
    input  logic       time_match,
    input  logic       btn_snooze,
    input  logic       btn_off,
    output logic       start,
    output logic       stop,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    localparam int unsigned TickW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SecMax = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC
                                                                     : RING_TIMEOUT_SEC;
    localparam int unsigned SecW   = (SecMax > 0) ? $clog2(SecMax + 1) : 1;

    localparam logic [TickW-1:0] TickLast  = TickW'(TICK_CYCLES - 1);
    localparam logic [DebW-1:0]  DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SecW-1:0]  SecLast   = SecW'(SecMax);
    localparam logic [SecW-1:0]  SecRing   = SecW'(RING_TIMEOUT_SEC);
    localparam logic [SecW-1:0]  SecSnooze = SecW'(SNOOZE_SEC);
    localparam logic [1:0]       MaxSnz    = 2'(MAX_SNOOZES);

    // Bit 0 carries the snooze button, bit 1 the off button.
    localparam int BtnSnz = 0;
    localparam int BtnOff = 1;

    typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 meta_q, sync_q;
    logic [1:0]                 deb_q, deb_d, evt_q;
    logic [1:0][DebW-1:0]       deb_cnt_q, deb_cnt_d;
    logic [TickW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SecW-1:0]            sec_q, sec_d;
    logic [1:0]                 snooze_count_q, snooze_count_d;
    logic                       start_q, stop_q, ringing_q, snoozing_q;
    logic                       tick;
    logic                       snz_evt, off_evt;

    // Two-flop synchronizers for the raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {btn_off, btn_snooze};
            sync_q <= meta_q;
        end
    end

    // Debounce: a new level must differ from the accepted one for DEBOUNCE_CYCLES in a row.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DebLast) begin
                    deb_d[b] = sync_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Debounce state and one-cycle press events on the accepted rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
            evt_q     <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            evt_q     <= deb_d & ~deb_q;
        end
    end

    assign snz_evt = evt_q[BtnSnz];
    assign off_evt = evt_q[BtnOff];
    assign tick    = (tick_cnt_q == TickLast);

    // Next state and snooze budget; off wins over snooze in the same cycle.
    always_comb begin
        state_d        = state_q;
        snooze_count_d = snooze_count_q;
        unique case (state_q)
            StIdle: begin
                if (time_match && alarm_en) state_d = StRinging;
            end
            StRinging: begin
                if (off_evt || !alarm_en || (sec_q == SecRing)) begin
                    state_d = StIdle;
                end else if (snz_evt && (snooze_count_q < MaxSnz)) begin
                    state_d        = StSnooze;
                    snooze_count_d = snooze_count_q + 2'd1;
                end
            end
            StSnooze: begin
                if (off_evt || !alarm_en) begin
                    state_d = StIdle;
                end else if (sec_q == SecSnooze) begin
                    state_d = StRinging;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) snooze_count_d = '0;
    end

    // Tick and seconds counters restart on every state entry; seconds saturate.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        sec_d      = sec_q;
        if (tick && (sec_q != SecLast)) sec_d = sec_q + 1'b1;
        if (state_d != state_q) begin
            tick_cnt_d = '0;
            sec_d      = '0;
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            tick_cnt_q     <= '0;
            sec_q          <= '0;
            snooze_count_q <= '0;
            start_q        <= 1'b0;
            stop_q         <= 1'b1;
            ringing_q      <= 1'b0;
            snoozing_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            sec_q          <= sec_d;
            snooze_count_q <= snooze_count_d;
            start_q        <= (state_d == StRinging) && (state_q != StRinging);
            stop_q         <= (state_d != StRinging);
            ringing_q      <= (state_d == StRinging);
            snoozing_q     <= (state_d == StSnooze);
        end
    end

    assign start        = start_q;
    assign stop         = stop_q;
    assign ringing      = ringing_q;
    assign snoozing     = snoozing_q;
    assign snooze_count = snooze_count_q;

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 62500000; clk cycles per one-second tick.
REQ-002 Parameter DEBOUNCE_CYCLES, default 625000; consecutive stable cycles required to accept a button level.
REQ-003 Parameter SNOOZE_SEC, default 300; snooze duration in seconds.
REQ-004 Parameter RING_TIMEOUT_SEC, default 60; unattended ring duration in seconds before auto-off.
REQ-005 Parameter MAX_SNOOZES, default 3; snoozes allowed per alarm event (1..3).
REQ-006 clk  input  1  single system clock, rising-edge active.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 alarm_en  input  1  alarm armed (synchronous level).
REQ-009 time_match  input  1  one-cycle pulse when current time equals alarm time (synchronous).
REQ-010 btn_snooze  input  1  raw asynchronous snooze button, active-high.
REQ-011 btn_off  input  1  raw asynchronous off button, active-high.
REQ-012 start  output  1  one-cycle pulse requesting the tone generator to begin its loop.
REQ-013 stop  output  1  level; high forces the tone generator idle.
REQ-014 ringing  output  1  state is RINGING.
REQ-015 snoozing  output  1  state is SNOOZE.
REQ-016 snooze_count  output  2  snoozes used in the current alarm event.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: counter clears on any level change; new level accepted after DEBOUNCE_CYCLES stable cycles.
REQ-018 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge; holding a button SHALL yield exactly one event; release SHALL yield none.
REQ-019 Tick counter SHALL count 0..TICK_CYCLES-1, wrap, and emit a one-cycle tick at wrap; it SHALL clear to 0 on every state entry.
REQ-020 A seconds counter SHALL increment on tick and clear on every state entry.
REQ-021 States SHALL be IDLE, RINGING, SNOOZE; state changes SHALL take effect on the clock edge following the qualifying event.
REQ-022 IDLE: time_match && alarm_en -> RINGING; button events ignored; snooze_count held at 0.
REQ-023 RINGING, priority high to low: off event -> IDLE; alarm_en low -> IDLE; seconds == RING_TIMEOUT_SEC -> IDLE; snooze event with snooze_count < MAX_SNOOZES -> SNOOZE and snooze_count+1; snooze event at MAX_SNOOZES ignored; time_match ignored.
REQ-024 SNOOZE: off event or alarm_en low -> IDLE; seconds == SNOOZE_SEC -> RINGING; snooze event and time_match ignored.
REQ-025 Entry to IDLE SHALL clear snooze_count.
REQ-026 start SHALL be high exactly during the first cycle in RINGING on every entry (initial and post-snooze), else low.
REQ-027 stop SHALL be low throughout RINGING (including the start cycle) and high in IDLE and SNOOZE.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-029 Simultaneous off and snooze events SHALL resolve as off.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, start 0, stop 1, ringing 0, snoozing 0, snooze_count 0, debounced levels 0, all counters 0.
REQ-031 Reset asserted mid-ring or mid-snooze SHALL drive stop high without waiting for a clk edge; a button held through reset release SHALL produce a press event once debounced.

Verification (TICK_CYCLES=10, DEBOUNCE_CYCLES=4, SNOOZE_SEC=3, RING_TIMEOUT_SEC=5, MAX_SNOOZES=2)
REQ-032 alarm_en=1, time_match pulse -> next cycle start=1 for one cycle, stop=0, ringing=1; same pulse with alarm_en=0 -> stop stays 1, no start.
REQ-033 In RINGING, btn_snooze held 8 cycles -> snoozing=1, stop=1, snooze_count=1; after 30 cycles -> single start pulse, ringing=1.
REQ-034 btn_off toggling every 2 cycles for 40 cycles -> no event, remains RINGING; then held 8 cycles -> IDLE, stop=1, snooze_count=0.
REQ-035 Two snoozes used, third snooze press -> ignored, snooze_count=2; no input for 50 cycles -> IDLE, stop=1.
REQ-036 btn_off and btn_snooze debounced on the same cycle in RINGING -> IDLE; rst_n low mid-ring -> stop=1, ringing=0 immediately, before next clk edge.
